// File: rtl/volatility_estimator_pkg.sv
// Shared fixed-point definitions for the pricing pipeline stages.
// Words are signed Q(W-32).32.
package volatility_estimator_pkg;
  localparam int FP_FRAC_BITS = 32;
  localparam int FP_WORD_BITS = 64;
  typedef logic signed [FP_WORD_BITS-1:0] fp_word_t;
endpackage

// File: rtl/volatility_estimator_sample_window_buf.sv
// N-entry sample register file for the sliding price window.
// The single address serves both the eviction read and the new write.
module sample_window_buf #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/volatility_estimator.sv
// Sliding-window mean and variance of the mid price.
// Three stages: running sums, shift to means, variance.
module volatility_estimator
  import volatility_estimator_pkg::*;
#(
  parameter int FP_WORD_SIZE = $bits(fp_word_t),
  parameter int WINDOW_LOG2  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic signed [FP_WORD_SIZE-1:0] i_mid_price,
  input  logic                           i_data_valid,
  output logic signed [FP_WORD_SIZE-1:0] o_volatility,
  output logic signed [FP_WORD_SIZE-1:0] o_mean,
  output logic                           o_data_valid
);

  localparam int SW = FP_WORD_SIZE + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] FILL_MAX =
    (WINDOW_LOG2+1)'(2**WINDOW_LOG2);

  function automatic logic signed [FP_WORD_SIZE-1:0] fp_mul(
    input logic signed [FP_WORD_SIZE-1:0] a,
    input logic signed [FP_WORD_SIZE-1:0] b
  );
    logic signed [2*FP_WORD_SIZE-1:0] p;
    p = a * b;
    return p[FP_WORD_SIZE+FP_FRAC_BITS-1:FP_FRAC_BITS];
  endfunction

  logic                           accept;
  logic                           full;
  logic [WINDOW_LOG2-1:0]         wr_ptr;
  logic [WINDOW_LOG2:0]           fill_cnt;
  logic signed [FP_WORD_SIZE-1:0] rd_data;
  logic signed [FP_WORD_SIZE-1:0] evict;
  logic signed [FP_WORD_SIZE-1:0] x_sq;
  logic signed [FP_WORD_SIZE-1:0] e_sq;
  logic signed [SW-1:0]           x_ext;
  logic signed [SW-1:0]           e_ext;
  logic signed [SW-1:0]           xs_ext;
  logic signed [SW-1:0]           es_ext;
  logic signed [SW-1:0]           s_sum;
  logic signed [SW-1:0]           q_sum;
  logic                           v1;
  logic                           v2;
  logic signed [FP_WORD_SIZE-1:0] mean_s2;
  logic signed [FP_WORD_SIZE-1:0] msq_s2;
  logic signed [FP_WORD_SIZE-1:0] var_raw;
  logic signed [FP_WORD_SIZE-1:0] var_clamped;

  assign accept = i_data_valid & ~i_reset;
  assign full   = (fill_cnt == FILL_MAX);

  sample_window_buf #(
    .WIDTH      (FP_WORD_SIZE),
    .DEPTH_LOG2 (WINDOW_LOG2)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (accept),
    .i_addr  (wr_ptr),
    .i_wdata (i_mid_price),
    .o_rdata (rd_data)
  );

  // Slots are never cleared, so nothing is evicted until the window is full.
  assign evict  = full ? rd_data : '0;
  assign x_sq   = fp_mul(i_mid_price, i_mid_price);
  assign e_sq   = fp_mul(evict, evict);
  assign x_ext  = {{WINDOW_LOG2{i_mid_price[FP_WORD_SIZE-1]}}, i_mid_price};
  assign e_ext  = {{WINDOW_LOG2{evict[FP_WORD_SIZE-1]}}, evict};
  assign xs_ext = {{WINDOW_LOG2{x_sq[FP_WORD_SIZE-1]}}, x_sq};
  assign es_ext = {{WINDOW_LOG2{e_sq[FP_WORD_SIZE-1]}}, e_sq};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      s_sum    <= '0;
      q_sum    <= '0;
      v1       <= 1'b0;
    end else begin
      v1 <= accept && (full || fill_cnt == FILL_MAX - 1'b1);
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        s_sum  <= s_sum + x_ext - e_ext;
        q_sum  <= q_sum + xs_ext - es_ext;
        if (!full) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Dropping the low bits of the sums is the arithmetic divide by N.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v2      <= 1'b0;
      mean_s2 <= '0;
      msq_s2  <= '0;
    end else begin
      v2      <= v1;
      mean_s2 <= s_sum[SW-1:WINDOW_LOG2];
      msq_s2  <= q_sum[SW-1:WINDOW_LOG2];
    end
  end

  assign var_raw     = msq_s2 - fp_mul(mean_s2, mean_s2);
  assign var_clamped = var_raw[FP_WORD_SIZE-1] ? '0 : var_raw;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_valid <= 1'b0;
      o_volatility <= '0;
      o_mean       <= '0;
    end else begin
      o_data_valid <= v2;
      if (v2) begin
        o_volatility <= var_clamped;
        o_mean       <= mean_s2;
      end
    end
  end

endmodule

// File: doc/volatility_estimator.md
VOLATILITY_ESTIMATOR -- requirements
Module: volatility_estimator

Interface
REQ-001 SHALL have parameter FP_WORD_SIZE, default 64: fixed-point word width; format is signed Q(FP_WORD_SIZE-32).32 (32 fraction bits).
REQ-002 SHALL have parameter WINDOW_LOG2, default 4: log2 of window depth N (N = 16 by default).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_mid_price, input, signed FP_WORD_SIZE bits: mid-price sample (Q.32); values are non-negative.
REQ-006 SHALL have port i_data_valid, input, 1 bit: i_mid_price is a new sample this cycle.
REQ-007 SHALL have port o_volatility, output, signed FP_WORD_SIZE bits: windowed variance sigma^2 (Q.32), the volatility input of the spread stage.
REQ-008 SHALL have port o_mean, output, signed FP_WORD_SIZE bits: windowed mean price (Q.32).
REQ-009 SHALL have port o_data_valid, output, 1 bit: o_volatility and o_mean are valid this cycle.

Function
REQ-010 SHALL keep the last N accepted samples in a circular buffer with a WINDOW_LOG2-bit write pointer that wraps from N-1 to 0.
REQ-011 SHALL accept a sample only on cycles with i_data_valid=1; there is no backpressure.
REQ-012 SHALL maintain a running sum S (FP_WORD_SIZE+WINDOW_LOG2 bits) and a running sum of squares Q (FP_WORD_SIZE+WINDOW_LOG2 bits).
REQ-013 SHALL form each square as the full 2*FP_WORD_SIZE product truncated to Q.32 (product bits [FP_WORD_SIZE+31:32]).
REQ-014 SHALL, per accepted sample x, replacing the evicted sample e, update S += x - e and Q += x^2 - e^2; while filling, e = 0.
REQ-015 SHALL keep a fill counter saturating at N; the window is "full" once N samples have been accepted since reset.
REQ-016 SHALL pipeline the computation in 3 stages: stage 1 is the buffer/sum update; stage 2 is mean = S>>>WINDOW_LOG2 and msq = Q>>>WINDOW_LOG2; stage 3 is var = msq - trunc_Q.32(mean*mean).
REQ-017 SHALL assert o_data_valid exactly 3 cycles after an accepted sample that leaves the window full, and deassert it otherwise.
REQ-018 SHALL raise no o_data_valid for the first N-1 samples after reset (warm-up); the Nth sample produces the first result.
REQ-019 SHALL clamp var to 0 when the stage-3 subtraction is negative (truncation artefact).
REQ-020 SHALL hold o_volatility and o_mean at their last values when o_data_valid=0.
REQ-021 SHALL sustain one sample per cycle; back-to-back samples yield back-to-back results.
REQ-022 SHALL, on the cycle where the pointer wraps, both evict and write slot 0 in the same cycle, reading the old value before the write.

Reset
REQ-023 SHALL, while i_reset=1, clear S, Q, the fill counter, the write pointer, all pipeline valid bits, o_volatility, o_mean and o_data_valid to 0.
REQ-024 SHALL not require buffer contents to be cleared; stale entries are never read because e = 0 while filling.
REQ-025 SHALL, when reset is asserted mid-operation, discard in-flight pipeline results and restart warm-up.
REQ-026 SHALL ignore i_data_valid in cycles where i_reset=1.

Structure
REQ-027 SHALL take FP_FRAC_BITS (32) and the fixed-point word typedef from the shared package used by the spread and reservation-price stages.
REQ-028 SHALL implement the circular buffer as a sub-module, sample_window_buf, a parameterised N-entry register file with combinational read of the eviction slot.

Verification
REQ-029 SHALL be verified for constant price: 16 samples of 100.0 -> first o_data_valid on cycle 3 after the 16th sample, o_mean=100.0, o_volatility=0.
REQ-030 SHALL be verified for alternating values: 100.0/102.0 repeated continuously -> o_mean=101.0, o_volatility=1.0 (0x1_0000_0000) on every valid result.
REQ-031 SHALL be verified for wrap/eviction: 16x 100.0 then 16x 104.0 back-to-back -> after the 32nd sample, mean=104.0 and var=0; the intermediate result after the 24th sample shows mean=102.0 and var=4.0.
REQ-032 SHALL be verified for valid gaps: the same samples as REQ-030 with random i_data_valid gaps -> identical result sequence; o_data_valid only 3 cycles after accepted samples.
REQ-033 SHALL be verified for mid-fill reset: reset after 10 samples, then 15 samples -> no o_data_valid; the 16th sample yields o_data_valid.
REQ-034 SHALL be verified for in-flight reset: reset asserted 1 cycle after the 16th sample -> o_data_valid stays 0 and all outputs read 0.
